// File: rtl/dcpu_inst_loader.sv
// DCPU instruction memory with byte-serial program loader and XOR checksum.
// Optional macro DCPU_LOADER_HALT_FILL_EN: unwritten words read as HALT (16'h0800).
module dcpu_inst_loader #(
    parameter int ADDR_W     = 8,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LoadReq,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    input  logic [ADDR_W-1:0] InstMemAddr,
    output logic [15:0]       Inst,
    output logic              Start,
    output logic              Loaded,
    output logic              Busy,
    output logic              Err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LO, S_HI, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_csum;
    logic [7:0]        r_lo_hold;
    logic              r_start;
    logic [15:0]       r_mem [DEPTH];

    logic              w_busy;
    logic              w_acc;
    logic              w_last;
    logic              w_wr;
    logic              w_csum_ok;
    logic              w_start_nxt;
    logic [15:0]       w_rd;

    assign w_busy    = (r_state == S_LEN) || (r_state == S_LO) ||
                       (r_state == S_HI)  || (r_state == S_CSUM);
    // A LoadReq cycle restarts the load, so any byte offered then is dropped.
    assign w_acc     = RxValid && w_busy && !LoadReq && !RST;
    assign w_last    = (r_cnt == ADDR_W'(1));
    assign w_wr      = w_acc && (r_state == S_HI);
    assign w_csum_ok = (RxData == r_csum);

    // Next-state decode and the start pulse that accompanies DONE entry.
    always_comb begin
        w_next      = r_state;
        w_start_nxt = 1'b0;
        if (LoadReq) begin
            w_next = S_LEN;
        end else if (w_acc) begin
            case (r_state)
                S_LEN:   w_next = S_LO;
                S_LO:    w_next = S_HI;
                S_HI:    w_next = w_last ? S_CSUM : S_LO;
                S_CSUM: begin
                    w_next      = w_csum_ok ? S_DONE : S_ERR;
                    w_start_nxt = AUTO_START && w_csum_ok;
                end
                default: w_next = r_state;
            endcase
        end
    end

    // State register and registered start pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= w_start_nxt;
        end
    end

    // Write pointer, word count, checksum and low-byte holding register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_csum    <= '0;
            r_lo_hold <= '0;
        end else if (LoadReq) begin
            r_wr_ptr <= '0;
            r_csum   <= '0;
        end else if (w_acc) begin
            case (r_state)
                S_LEN: begin
                    r_cnt  <= ADDR_W'(RxData);
                    r_csum <= RxData;
                end
                S_LO: begin
                    r_lo_hold <= RxData;
                    r_csum    <= r_csum ^ RxData;
                end
                S_HI: begin
                    r_csum   <= r_csum ^ RxData;
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    r_cnt    <= r_cnt - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Memory array write; contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {RxData, r_lo_hold};
        end
    end

`ifdef DCPU_LOADER_HALT_FILL_EN
    logic [DEPTH-1:0] r_vld;

    // Per-word written flags, cleared whenever a new program begins.
    always_ff @(posedge CLK) begin
        if (RST || LoadReq) begin
            r_vld <= '0;
        end else if (w_wr) begin
            r_vld[r_wr_ptr] <= 1'b1;
        end
    end

    // Asynchronous read; unwritten words halt a runaway core.
    always_comb begin
        w_rd = r_mem[InstMemAddr];
        if (!r_vld[InstMemAddr]) begin
            w_rd = 16'h0800;
        end
    end
`else
    // Asynchronous read of the addressed word.
    always_comb begin
        w_rd = r_mem[InstMemAddr];
    end
`endif

    assign Inst    = w_busy ? 16'h0000 : w_rd;
    assign RxReady = w_busy;
    assign Busy    = w_busy;
    assign Start   = r_start;
    assign Loaded  = (r_state == S_DONE);
    assign Err     = (r_state == S_ERR);

endmodule

// File: tb/tb_dcpu_inst_loader.sv
// Directed bench for dcpu_inst_loader: per-cycle vector table plus
// hand-written full-depth load and optional HALT-fill checks.
module tb_dcpu_inst_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        LoadReq = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic        RxReady;
    logic [7:0]  InstMemAddr = 8'h00;
    logic [15:0] Inst;
    logic        Start;
    logic        Loaded;
    logic        Busy;
    logic        Err;

    int total = 0;
    int bad   = 0;

`ifdef DCPU_LOADER_HALT_FILL_EN
    localparam logic [15:0] KEEP0 = 16'h0800;
    localparam logic [15:0] KEEP1 = 16'h0800;
`else
    localparam logic [15:0] KEEP0 = 16'h5678;
    localparam logic [15:0] KEEP1 = 16'hABCD;
`endif

    dcpu_inst_loader #(.ADDR_W(8), .AUTO_START(1'b1)) dut (
        .CLK(CLK), .RST(RST), .LoadReq(LoadReq),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .InstMemAddr(InstMemAddr), .Inst(Inst), .Start(Start),
        .Loaded(Loaded), .Busy(Busy), .Err(Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        lr;
        logic [7:0]  d;
        logic        v;
        logic [7:0]  a;
        logic        rdy;
        logic        busy;
        logic        ld;
        logic        err;
        logic        st;
        logic        ci;
        logic [15:0] inst;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic rst, logic lr, logic [7:0] d, logic v, logic [7:0] a,
        logic rdy, logic busy, logic ld, logic err, logic st,
        logic ci, logic [15:0] inst);
        vec_t r;
        r.rst = rst; r.lr = lr; r.d = d; r.v = v; r.a = a;
        r.rdy = rdy; r.busy = busy; r.ld = ld; r.err = err; r.st = st;
        r.ci = ci; r.inst = inst;
        return r;
    endfunction

    // Busy-state byte: ready and busy high, no status.
    function automatic vec_t bb(logic [7:0] d);
        return mk(0, 0, d, 1, 0, 1, 1, 0, 0, 0, 1, 16'h0000);
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(logic rst, logic lr, logic [7:0] d, logic v,
                        logic [7:0] a);
        RST = rst; LoadReq = lr; RxData = d; RxValid = v;
        InstMemAddr = a;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Normal load: csum 02^34^12^CD^AB = 42
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h02));
        tbl.push_back(bb(8'h34));
        tbl.push_back(bb(8'h12));
        tbl.push_back(bb(8'hCD));
        tbl.push_back(bb(8'hAB));
        tbl.push_back(mk(0, 0, 8'h42, 1, 1, 0, 0, 1, 0, 1, 1, 16'hABCD));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(0, 0, 8'h55, 1, 1, 0, 0, 1, 0, 0, 1, 16'hABCD));
        // Bad checksum
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h02));
        tbl.push_back(bb(8'h34));
        tbl.push_back(bb(8'h12));
        tbl.push_back(bb(8'hCD));
        tbl.push_back(bb(8'hAB));
        tbl.push_back(mk(0, 0, 8'h41, 1, 1, 0, 0, 0, 1, 0, 1, 16'hABCD));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 16'hABCD));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        // Gap of 3 cycles between LO and HI of word 0; csum 4A
        tbl.push_back(bb(8'h02));
        tbl.push_back(bb(8'h78));
        tbl.push_back(mk(0, 0, 8'h56, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h56, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h56, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h56));
        tbl.push_back(bb(8'hCD));
        tbl.push_back(bb(8'hAB));
        tbl.push_back(mk(0, 0, 8'h4A, 1, 0, 0, 0, 1, 0, 1, 1, 16'h5678));
        // Reset mid-word
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h01));
        tbl.push_back(bb(8'h11));
        tbl.push_back(mk(1, 0, 8'h22, 1, 0, 0, 0, 0, 0, 0, 1, KEEP0));
        tbl.push_back(mk(0, 0, 8'h22, 1, 0, 0, 0, 0, 0, 0, 1, KEEP0));
        // Restart: one word 3322, csum 01^22^33 = 10
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h01));
        tbl.push_back(bb(8'h22));
        tbl.push_back(bb(8'h33));
        tbl.push_back(mk(0, 0, 8'h10, 1, 0, 0, 0, 1, 0, 1, 1, 16'h3322));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, KEEP1));
        // LoadReq mid-stream with a byte offered that cycle
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h02));
        tbl.push_back(bb(8'h44));
        tbl.push_back(mk(0, 1, 8'h55, 1, 0, 1, 1, 0, 0, 0, 1, 0));
        tbl.push_back(bb(8'h01));
        tbl.push_back(bb(8'hEE));
        tbl.push_back(bb(8'hFF));
        tbl.push_back(mk(0, 0, 8'h10, 1, 0, 0, 0, 1, 0, 1, 1, 16'hFFEE));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, KEEP1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].lr, tbl[i].d, tbl[i].v, tbl[i].a);
            chk($sformatf("v%0d.rdy", i), 16'(RxReady), 16'(tbl[i].rdy));
            chk($sformatf("v%0d.busy", i), 16'(Busy), 16'(tbl[i].busy));
            chk($sformatf("v%0d.ld", i), 16'(Loaded), 16'(tbl[i].ld));
            chk($sformatf("v%0d.err", i), 16'(Err), 16'(tbl[i].err));
            chk($sformatf("v%0d.st", i), 16'(Start), 16'(tbl[i].st));
            if (tbl[i].ci) begin
                chk($sformatf("v%0d.inst", i), Inst, tbl[i].inst);
            end
        end

        // Full depth: length 00 -> 256 words, word i = i, csum 00
        step(0, 1, 0, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 8'(i), 1, 0);
            step(0, 0, 8'h00, 1, 0);
            if (i == 254 || i == 255) begin
                chk($sformatf("full.busy%0d", i), 16'(Busy), 16'h1);
                chk($sformatf("full.st%0d", i), 16'(Start), 16'h0);
            end
        end
        step(0, 0, 8'h00, 1, 255);
        chk("full.start", 16'(Start), 16'h1);
        chk("full.loaded", 16'(Loaded), 16'h1);
        chk("full.m255", Inst, 16'h00FF);
        step(0, 0, 0, 0, 0);
        chk("full.start_off", 16'(Start), 16'h0);
        chk("full.m0", Inst, 16'h0000);
        InstMemAddr = 8'd128;
        #1;
        chk("full.m128", Inst, 16'h0080);

`ifdef DCPU_LOADER_HALT_FILL_EN
        step(1, 0, 0, 0, 0);
        for (int a = 0; a < 256; a += 85) begin
            InstMemAddr = 8'(a);
            #1;
            chk($sformatf("halt.rst%0d", a), Inst, 16'h0800);
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 8'h02, 1, 0);
        step(0, 0, 8'h34, 1, 0);
        step(0, 0, 8'h12, 1, 0);
        step(0, 0, 8'hCD, 1, 0);
        step(0, 0, 8'hAB, 1, 0);
        step(0, 0, 8'h42, 1, 2);
        chk("halt.ld", 16'(Loaded), 16'h1);
        chk("halt.a2", Inst, 16'h0800);
        InstMemAddr = 8'd1;
        #1;
        chk("halt.a1", Inst, 16'hABCD);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
